// File: rtl/spi_hs_tx_b2a.sv
// Source end of a 4-phase req/ack word transfer out of the clk_b domain, with a one-deep pending buffer.
// Optional watchdog on a stuck a-domain partner: define SPI_HS_TIMEOUT_EN.
module spi_hs_tx_b2a #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 3,
    parameter int TO_CYCLES   = 1024
) (
    input  logic          clk_b,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          req_a,
    output logic [DW-1:0] dat_a,
    input  logic          ack_a,
    output logic          busy,
    output logic          done_pulse,
    output logic          timeout_err,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // Handshake on the word side: a word moves when in_valid && in_ready on a clk_b edge;
    // in_valid may rise at any time and in_ready never depends on in_valid.

    if (SYNC_STAGES < 2 || TO_CYCLES < 2) begin : g_param_check
        $error("spi_hs_tx_b2a: SYNC_STAGES and TO_CYCLES must both be >= 2");
    end

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_q, req_d;
    logic [DW-1:0]          dat_q, dat_d;
    logic [DW-1:0]          pend_q, pend_d;
    logic                   pend_v_q, pend_v_d;
    logic                   done_q, done_d;
    logic                   ack_s;
    logic                   accept;
    logic                   consumed;

    assign ack_s  = sync_q[SYNC_STAGES-1];
    assign accept = in_valid && !pend_v_q;
    assign sync_d = {sync_q[SYNC_STAGES-2:0], ack_a};

`ifdef SPI_HS_TIMEOUT_EN
    localparam int CW = $clog2(TO_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          to_hit;

    assign to_hit = (cnt_q == CW'(TO_CYCLES - 1));

    // Counter restarts on every state change so REQ and RELEASE each get a full window.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        dat_d    = dat_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        done_d   = 1'b0;
        consumed = 1'b0;
`ifdef SPI_HS_TIMEOUT_EN
        err_d    = accept ? 1'b0 : err_q;
`endif
        case (state_q)
            IDLE: begin
                // A stale ack from the previous transfer must clear before a new request starts.
                if (!ack_s) begin
                    if (pend_v_q) begin
                        dat_d    = pend_q;
                        pend_v_d = 1'b0;
                        req_d    = 1'b1;
                        state_d  = REQ;
                    end else if (accept) begin
                        dat_d    = in_data;
                        req_d    = 1'b1;
                        state_d  = REQ;
                        consumed = 1'b1;
                    end
                end
            end
            REQ: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = RELEASE;
                end
`ifdef SPI_HS_TIMEOUT_EN
                else if (to_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end
`endif
            end
            RELEASE: begin
                if (!ack_s) begin
                    state_d = IDLE;
                end
`ifdef SPI_HS_TIMEOUT_EN
                else if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (accept && !consumed) begin
            pend_d   = in_data;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk_b or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sync_q   <= '0;
            req_q    <= 1'b0;
            dat_q    <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            req_q    <= req_d;
            dat_q    <= dat_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            done_q   <= done_d;
        end
    end

    assign in_ready   = !pend_v_q;
    assign busy       = (state_q != IDLE) || pend_v_q;
    assign req_a      = req_q;
    assign dat_a      = dat_q;
    assign done_pulse = done_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_hs_tx_b2a.sv
// Bench for spi_hs_tx_b2a: directed handshake scenarios plus random words, checked by an expected-word queue.
module tb_spi_hs_tx_b2a;

  localparam int DW = 8;
  localparam int SS = 3;
`ifdef SPI_HS_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 1024;
`endif

  logic          clk_b = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          req_a;
  logic [DW-1:0] dat_a;
  logic          ack_a = 1'b0;
  logic          busy;
  logic          done_pulse;
  logic          timeout_err;
  logic [1:0]    dbg_state;

  logic [DW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            done_cnt = 0;
  int            exp_done = 0;
  int            done_snap;

  spi_hs_tx_b2a #(.DW(DW), .SYNC_STAGES(SS), .TO_CYCLES(TO)) dut (
    .clk_b(clk_b), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req_a(req_a), .dat_a(dat_a), .ack_a(ack_a),
    .busy(busy), .done_pulse(done_pulse), .timeout_err(timeout_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk_b = ~clk_b;

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected finish before 300000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_b);
  endtask

  // scoreboard: each done_pulse must present the oldest accepted word
  always @(negedge clk_b) begin
    if (rst_n && done_pulse) begin
      done_cnt++;
      if (exp_q.size() == 0) check("done_extra", 32'd1, 32'd0);
      else check("done_word", 32'(dat_a), 32'(exp_q.pop_front()));
    end
  end

  // driver tasks (all called aligned to a falling edge)
  task automatic send(input logic [DW-1:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        exp_q.push_back(d);
        ok = 1'b1;
      end
      @(negedge clk_b);
    end
    in_valid = 1'b0;
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_req(input string tag, input logic lvl, input int budget);
    for (int i = 0; i < budget && req_a !== lvl; i++) @(negedge clk_b);
    check(tag, 32'(req_a), 32'(lvl));
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk_b);
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  task automatic handshake();
    wait_req("hs_req_rise", 1'b1, 40);
    tick($urandom_range(0, 3));
    ack_a = 1'b1;
    exp_done++;
    wait_req("hs_req_fall", 1'b0, 40);
    tick($urandom_range(0, 2));
    ack_a = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    do_reset();

    // reset state
    check("rst_req", 32'(req_a), 32'd0);
    check("rst_dat", 32'(dat_a), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_pulse), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // single word with exact latencies
    send(8'hA5);
    check("t1_req", 32'(req_a), 32'd1);
    check("t1_dat", 32'(dat_a), 32'hA5);
    ack_a = 1'b1;
    exp_done++;
    tick(SS);
    check("t1_req_hold", 32'(req_a), 32'd1);
    check("t1_done_early", 32'(done_pulse), 32'd0);
    tick(1);
    check("t1_req_fall", 32'(req_a), 32'd0);
    check("t1_done", 32'(done_pulse), 32'd1);
    tick(1);
    check("t1_done_once", 32'(done_pulse), 32'd0);
    ack_a = 1'b0;
    tick(SS);
    check("t1_busy_hold", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_clear", 32'(busy), 32'd0);

    // back-to-back: second word waits in pend
    send(8'h11);
    send(8'h22);
    check("t2_ready", 32'(in_ready), 32'd0);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_dat_first", 32'(dat_a), 32'h11);
    handshake();
    check("t2_dat_hold", 32'(dat_a), 32'h11);
    wait_req("t2_req_second", 1'b1, 40);
    check("t2_dat_second", 32'(dat_a), 32'h22);
    check("t2_ready_again", 32'(in_ready), 32'd1);
    handshake();
    wait_idle(40);

    // stale ack held through reset
    ack_a = 1'b1;
    do_reset();
    tick(SS + 2);
    send(8'h3C);
    check("t3_ready", 32'(in_ready), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    tick(5);
    check("t3_req_low", 32'(req_a), 32'd0);
    ack_a = 1'b0;
    tick(SS);
    check("t3_req_wait", 32'(req_a), 32'd0);
    tick(1);
    check("t3_req_rise", 32'(req_a), 32'd1);
    check("t3_dat", 32'(dat_a), 32'h3C);
    handshake();
    wait_idle(40);

    // reset in REQ with a pending word
    send(8'h44);
    send(8'h55);
    check("t4_pend_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("t4_req", 32'(req_a), 32'd0);
    check("t4_dat", 32'(dat_a), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    done_snap = done_cnt;
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("t4_no_done", 32'(done_cnt), 32'(done_snap));
    check("t4_req_idle", 32'(req_a), 32'd0);

`ifdef SPI_HS_TIMEOUT_EN
    // never acknowledge: request gives up after TO cycles in REQ
    send(8'h5A);
    done_snap = done_cnt;
    tick(TO - 1);
    check("t5_req_hold", 32'(req_a), 32'd1);
    check("t5_err_early", 32'(timeout_err), 32'd0);
    tick(1);
    check("t5_req_fall", 32'(req_a), 32'd0);
    check("t5_err", 32'(timeout_err), 32'd1);
    check("t5_no_done", 32'(done_pulse), 32'd0);
    void'(exp_q.pop_front());
    tick(3);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_err_sticky", 32'(timeout_err), 32'd1);
    check("t5_no_done_cnt", 32'(done_cnt), 32'(done_snap));
    send(8'h66);
    check("t5_err_clear", 32'(timeout_err), 32'd0);
    handshake();
    wait_idle(40);
`else
    // without the watchdog a silent partner just keeps req_a high
    send(8'h5A);
    tick(60);
    check("t5_req_wait", 32'(req_a), 32'd1);
    check("t5_err_tied", 32'(timeout_err), 32'd0);
    handshake();
    wait_idle(40);
`endif

    // random words, sometimes two in flight
    for (int i = 0; i < 8; i++) begin
      send(DW'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        send(DW'($urandom_range(0, 255)));
        handshake();
      end
      handshake();
      tick($urandom_range(0, 3));
    end
    wait_idle(60);
    tick(2);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("done_total", 32'(done_cnt), 32'(exp_done));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_hs_tx_b2a.md
Name: spi_hs_tx_b2a

Overview:
Source end of a 4-phase req/ack handshake that carries a multi-bit word out of the clk_b domain into the a-domain. It accepts words on a valid/ready interface and holds each word stable on dat_a while driving req_a. It synchronises the returning asynchronous ack_a internally. A one-deep pending buffer lets the next word be accepted while a transfer is in flight.

Parameters:
DW, 8, data word width
SYNC_STAGES, 3, flops in the ack_a synchroniser chain (legal range >= 2)
TO_CYCLES, 1024, timeout limit in clk_b cycles (used only with SPI_HS_TIMEOUT_EN)

Ports:
clk_b  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  word offered
in_ready  out  1  word accepted when in_valid && in_ready
in_data  in  DW  word to transfer
req_a  out  1  request to a-domain, registered
dat_a  out  DW  held word, registered
ack_a  in  1  acknowledge from a-domain, asynchronous to clk_b
busy  out  1  transfer in flight or word pending
done_pulse  out  1  one clk_b pulse per word delivered
timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values: req_a=0, dat_a=0, in_ready=1 (pending buffer empty), busy=0, done_pulse=0, timeout_err=0. FSM=IDLE, synchroniser flops=0, pend_v=0.
- ack_s = last stage of the SYNC_STAGES-flop chain on ack_a. Only ack_s is used by logic.
- in_ready = !pend_v.
- FSM states: IDLE, REQ, RELEASE.
- IDLE, start condition (requires ack_s==0):
  - pend_v=1: load pend->dat_a, clear pend_v, set req_a=1, go to REQ.
  - Else, an accept this cycle loads in_data->dat_a directly, sets req_a=1, goes to REQ. req_a and dat_a are visible the next cycle.
  - If ack_s==1 in IDLE, stay in IDLE. Words still go to pend until pend is full.
- Any accept not consumed directly in IDLE is written to pend (pend_v=1).
- REQ: req_a=1. When ack_s==1, go to RELEASE, req_a<=0, done_pulse<=1 for exactly one cycle.
- RELEASE: req_a=0. When ack_s==0, go to IDLE. A pending word may start on the following cycle (no same-cycle chaining).
- dat_a changes only on an IDLE->REQ transition. It is stable from req_a rise until the next start.
- busy = (FSM!=IDLE) || pend_v.
- Latency:
  - ack_a rise -> done_pulse/req_a fall: SYNC_STAGES+1 clk_b edges.
  - Accept into empty IDLE -> req_a high: 1 cycle.
- Simultaneous events:
  - An accept in the same cycle IDLE consumes pend is impossible, because in_ready=0 whenever pend_v=1.
  - An accept in REQ/RELEASE fills pend. The FSM transition is unaffected.
- Reset mid-operation: all state returns to reset values, the in-flight and pending words are discarded, and req_a drops asynchronously. The a-domain end must be reset in the same reset domain.
- DW has no arithmetic; the data path is pass-through registers only.

Optional Feature:
SPI_HS_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and to RELEASE and increments each cycle in those states.
  - Reaching TO_CYCLES-1 in REQ: req_a<=0, go to RELEASE, no done_pulse, timeout_err<=1.
  - Reaching TO_CYCLES-1 in RELEASE: go to IDLE, timeout_err<=1.
  - The timed-out word is dropped.
  - timeout_err clears only on reset or on the next accepted word.
- Undefined: no counter. The FSM waits indefinitely and timeout_err is tied to 0.

Test Plan:
- Single word: reset, in_valid=1, in_data=8'hA5 for one cycle -> next cycle req_a=1, dat_a=A5. Drive ack_a=1 -> done_pulse one cycle, req_a=0 exactly 4 cycles after the ack_a edge. Drop ack_a -> busy=0 4 cycles later.
- Back-to-back: offer 8'h11, then 8'h22 while in REQ -> in_ready=0 after 22 is accepted. dat_a=11 until the first handshake completes, then dat_a=22 with req_a=1. Two done_pulses total, order 11,22.
- Stale ack: hold ack_a=1 from reset, offer 8'h3C -> word sits in pend and req_a stays 0. Release ack_a -> req_a rises after the ack_s fall plus 1 cycle.
- Reset mid-transfer: assert rst_n=0 while in REQ with pend_v=1 -> req_a, dat_a, busy, in_ready return to 0,0,0,1 immediately. No done_pulse after release.
- Timeout (macro defined, TO_CYCLES=16): offer 8'h5A and never raise ack_a -> req_a falls and timeout_err=1 after 16 cycles in REQ, no done_pulse. Next accept clears timeout_err.
